// File: rtl/ray_thread_receiver.sv
// ray_thread_receiver
// Consumer end of the pixel-thread interface. Incoming (pixel_x, pixel_y)
// beats are buffered in a DEPTH-entry FIFO. Each thread is then turned into
// a primary-ray direction in an output register, which is presented to the
// ray core over a valid/ready handshake. Frame completion is also tracked.
//
// Optional feature: define RANGE_CHECK_EN to drop beats with out-of-range
// coordinates and flag them on range_err. Without it every beat is written
// and range_err stays 0.
//
// Ports
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous reset, active-low
//   pixel_x/y      in   thread coordinates (10b)
//   valid          in   thread beat present this cycle
//   ray_core_free  out  sender may issue a thread next cycle
//   ray_valid      out  ray output valid
//   ray_ready      in   ray core accepts ray
//   ray_px/py      out  pass-through pixel coordinates
//   ray_dir_x/y/z  out  signed 12b ray direction
//   ray_last       out  ray is the last pixel of the frame
//   frame_done     out  one-cycle pulse after the last ray handshakes
//   frame_count    out  completed frames (wraps)
//   overflow       out  sticky: beat dropped because the FIFO was full
//   range_err      out  sticky: out-of-range beat dropped (RANGE_CHECK_EN)
module ray_thread_receiver #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 4,
    parameter int FOCAL  = 320
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               valid,
    output logic               ray_core_free,
    output logic               ray_valid,
    input  logic               ray_ready,
    output logic [9:0]         ray_px,
    output logic [9:0]         ray_py,
    output logic signed [11:0] ray_dir_x,
    output logic signed [11:0] ray_dir_y,
    output logic signed [11:0] ray_dir_z,
    output logic               ray_last,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic               overflow,
    output logic               range_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [19:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               r_ray_valid;
    logic [9:0]         r_ray_px;
    logic [9:0]         r_ray_py;
    logic signed [11:0] r_dir_x;
    logic signed [11:0] r_dir_y;
    logic               r_ray_last;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;
    logic               r_overflow;
    logic               r_range_err;

    logic               w_full;
    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic [CW:0]        w_occ;
    logic [19:0]        w_head;
    logic [9:0]         w_hx;
    logic [9:0]         w_hy;

`ifdef RANGE_CHECK_EN
    assign w_in_range = (pixel_x < 10'(WIDTH)) && (pixel_y < 10'(HEIGHT));
`else
    assign w_in_range = 1'b1;
`endif

    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = valid && !w_full && w_in_range;
    // Output register refills whenever it is empty or being consumed.
    assign w_pop  = (r_count != '0) && (!r_ray_valid || ray_ready);

    // Pops are deliberately ignored: the sender reacts one cycle late, so
    // only a guaranteed free slot may be advertised.
    assign w_occ         = {1'b0, r_count} + {{CW{1'b0}}, valid};
    assign ray_core_free = (w_occ < (CW+1)'(DEPTH));

    assign w_head = r_mem[r_rd_ptr];
    assign w_hx   = w_head[19:10];
    assign w_hy   = w_head[9:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pixel_x, pixel_y};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ray_valid   <= 1'b0;
            r_ray_px      <= '0;
            r_ray_py      <= '0;
            r_dir_x       <= '0;
            r_dir_y       <= '0;
            r_ray_last    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_range_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ray_valid <= 1'b1;
                r_ray_px    <= w_hx;
                r_ray_py    <= w_hy;
                r_dir_x     <= {2'b00, w_hx} - 12'(WIDTH / 2);
                r_dir_y     <= 12'(HEIGHT / 2) - {2'b00, w_hy};
                r_ray_last  <= (w_hx == 10'(WIDTH - 1)) && (w_hy == 10'(HEIGHT - 1));
            end else if (ray_ready) begin
                r_ray_valid <= 1'b0;
            end

            r_frame_done <= r_ray_valid && ray_ready && r_ray_last;
            if (r_ray_valid && ray_ready && r_ray_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (valid && w_full) begin
                r_overflow <= 1'b1;
            end
            // w_in_range is constant 1 without RANGE_CHECK_EN, so this never sets.
            if (valid && !w_in_range) begin
                r_range_err <= 1'b1;
            end
        end
    end

    assign ray_valid   = r_ray_valid;
    assign ray_px      = r_ray_px;
    assign ray_py      = r_ray_py;
    assign ray_dir_x   = r_dir_x;
    assign ray_dir_y   = r_dir_y;
    assign ray_dir_z   = 12'(FOCAL);
    assign ray_last    = r_ray_last;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign range_err   = r_range_err;

endmodule

// File: tb/tb_ray_thread_receiver.sv
module tb_ray_thread_receiver;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int DEPTH  = 4;
    localparam int FOCAL  = 320;

    logic               clk = 1'b0;
    logic               rst;
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic               valid;
    logic               ray_core_free;
    logic               ray_valid;
    logic               ray_ready;
    logic [9:0]         ray_px;
    logic [9:0]         ray_py;
    logic signed [11:0] ray_dir_x;
    logic signed [11:0] ray_dir_y;
    logic signed [11:0] ray_dir_z;
    logic               ray_last;
    logic               frame_done;
    logic [15:0]        frame_count;
    logic               overflow;
    logic               range_err;

    always #5 clk = ~clk;

    ray_thread_receiver #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH), .FOCAL(FOCAL)) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .valid(valid),
        .ray_core_free(ray_core_free), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_px(ray_px), .ray_py(ray_py), .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y),
        .ray_dir_z(ray_dir_z), .ray_last(ray_last), .frame_done(frame_done),
        .frame_count(frame_count), .overflow(overflow), .range_err(range_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of buffered threads plus one output slot.
    int m_q[$];
    bit m_v;
    int m_x, m_y, m_dx, m_dy;
    bit m_last, m_fd, m_ovf, m_rerr;
    int m_fc;
    bit last_free;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_v = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
        m_last = 0; m_fd = 0; m_fc = 0; m_ovf = 0; m_rerr = 0;
    endtask

    // One clock: drive, check ray_core_free, advance model, edge, check all outputs.
    task automatic cycle(input bit r, input bit v, input int x, input int y, input bit rdy);
        bit hs, full, acc, inr;
        int d;
        rst = r; valid = v; pixel_x = 10'(x); pixel_y = 10'(y); ray_ready = rdy;
        #1;
        last_free = ray_core_free;
        chk("ray_core_free", int'(ray_core_free), int'((m_q.size() + int'(v)) < DEPTH));
        if (!r) begin
            model_reset();
        end else begin
            hs   = m_v && rdy;
            full = (m_q.size() == DEPTH);
            inr  = (x < WIDTH) && (y < HEIGHT);
            m_fd = hs && m_last;
            if (m_fd) m_fc = (m_fc + 1) % 65536;
            if (v && full) m_ovf = 1;
`ifdef RANGE_CHECK_EN
            if (v && !inr) m_rerr = 1;
            acc = v && !full && inr;
`else
            acc = v && !full;
`endif
            if (m_q.size() > 0 && (!m_v || rdy)) begin
                d = m_q.pop_front();
                m_v = 1; m_x = d / 1024; m_y = d % 1024;
                m_dx = m_x - WIDTH / 2;
                m_dy = HEIGHT / 2 - m_y;
                m_last = (m_x == WIDTH - 1) && (m_y == HEIGHT - 1);
            end else if (rdy) begin
                m_v = 0;
            end
            if (acc) m_q.push_back(x * 1024 + y);
        end
        @(posedge clk);
        #1;
        chk("ray_valid", int'(ray_valid), int'(m_v));
        chk("ray_px", int'(ray_px), m_x);
        chk("ray_py", int'(ray_py), m_y);
        chk("ray_dir_x", int'(ray_dir_x), m_dx);
        chk("ray_dir_y", int'(ray_dir_y), m_dy);
        chk("ray_dir_z", int'(ray_dir_z), FOCAL);
        chk("ray_last", int'(ray_last), int'(m_last));
        chk("frame_done", int'(frame_done), int'(m_fd));
        chk("frame_count", int'(frame_count), m_fc);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("range_err", int'(range_err), int'(m_rerr));
    endtask

    typedef struct {
        bit r; bit v; int x; int y; bit rdy;
        bit e_rv; int e_dx; int e_dy; bit e_last; bit e_fd; int e_fc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int k, seen, sdx;
        int got[$];

        model_reset();
        rst = 1'b0; valid = 1'b0; pixel_x = '0; pixel_y = '0; ray_ready = 1'b0;

        // Reset with valid held, single thread, then the frame-end pixel.
        tbl[0] = '{0, 1,   5,   5, 1,  0,    0,    0, 0, 0, 0};
        tbl[1] = '{0, 1,   5,   5, 1,  0,    0,    0, 0, 0, 0};
        tbl[2] = '{0, 1,   5,   5, 1,  0,    0,    0, 0, 0, 0};
        tbl[3] = '{1, 1,  10,  20, 1,  0,    0,    0, 0, 0, 0};
        tbl[4] = '{1, 0,   0,   0, 1,  1, -310,  220, 0, 0, 0};
        tbl[5] = '{1, 1, 639, 479, 1,  0, -310,  220, 0, 0, 0};
        tbl[6] = '{1, 0,   0,   0, 1,  1,  319, -239, 1, 0, 0};
        tbl[7] = '{1, 0,   0,   0, 1,  0,  319, -239, 1, 1, 1};
        tbl[8] = '{1, 0,   0,   0, 1,  0,  319, -239, 1, 0, 1};

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].rdy);
            chk("tbl_ray_valid", int'(ray_valid), int'(tbl[i].e_rv));
            chk("tbl_dir_x", int'(ray_dir_x), tbl[i].e_dx);
            chk("tbl_dir_y", int'(ray_dir_y), tbl[i].e_dy);
            chk("tbl_last", int'(ray_last), int'(tbl[i].e_last));
            chk("tbl_frame_done", int'(frame_done), int'(tbl[i].e_fd));
            chk("tbl_frame_count", int'(frame_count), tbl[i].e_fc);
            chk("tbl_overflow", int'(overflow), 0);
        end

        // Backpressure: sender honours ray_core_free with one cycle of latency.
        last_free = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (last_free) begin
                cycle(1, 1, 100 + k, 7, 0);
                k++;
            end else begin
                cycle(1, 0, 0, 0, 0);
            end
        end
        chk("bp_accepted", k, DEPTH + 1);
        chk("bp_overflow", int'(overflow), 0);
        chk("bp_free_low", int'(last_free), 0);

        // Forced overflow while full; must stay sticky.
        cycle(1, 1, 7, 7, 0);
        chk("ovf_set", int'(overflow), 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        chk("ovf_sticky", int'(overflow), 1);

        // Drain: remaining rays must come out in order (first one already consumed above).
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (ray_valid) got.push_back(int'(ray_px));
            cycle(1, 0, 0, 0, 1);
        end
        chk("drain_count", got.size(), DEPTH);
        for (int i = 0; i < got.size() && i < DEPTH; i++) begin
            chk("drain_order", got[i], 101 + i);
        end

        // Out-of-range coordinate.
        seen = 0; sdx = 0;
        cycle(1, 1, 640, 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (ray_valid) begin seen++; sdx = int'(ray_dir_x); end
            cycle(1, 0, 0, 0, 1);
        end
`ifdef RANGE_CHECK_EN
        chk("range_no_ray", seen, 0);
        chk("range_err_set", int'(range_err), 1);
`else
        chk("range_ray_seen", seen, 1);
        chk("range_dir_x", sdx, 320);
        chk("range_err_tied", int'(range_err), 0);
`endif

        // Randomized traffic against the model, with occasional mid-run resets.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit rr, vv, rd;
            int xx, yy;
            rr = ($urandom_range(0, 149) != 0);
            vv = (i % 200 < 100) ? (last_free && $urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1;
            rd = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                xx = WIDTH - 1; yy = HEIGHT - 1;
            end else begin
                xx = $urandom_range(0, WIDTH - 1); yy = $urandom_range(0, HEIGHT - 1);
            end
            cycle(rr, vv, xx, yy, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
